// File: rtl/dispatch_pair_if.sv
// Dispatch-stage bus bundle: FIFO head view, retire handshake, issue bundle and
// performance counters. The slave modport is the dispatch stage itself, the
// master modport is whoever feeds it (FIFO/test driver).
interface dispatch_pair_if #(
  parameter int ENTRY_W = 64,
  parameter int CNT_W   = 32
);
  logic                    flush;
  logic [1:0]              head_valid;
  logic [1:0][ENTRY_W-1:0] head_data;
  logic [1:0]              dqueue_en;
  logic [1:0]              invalid_en;
  logic                    stall;
  logic                    serial_done;
  logic [1:0]              issue_valid;
  logic [1:0][ENTRY_W-1:0] issue_data;
  logic [CNT_W-1:0]        pair_cnt;
  logic [CNT_W-1:0]        stall_cnt;

  modport slave (
    input  flush, head_valid, head_data, stall, serial_done,
    output dqueue_en, invalid_en, issue_valid, issue_data, pair_cnt, stall_cnt
  );

  modport master (
    output flush, head_valid, head_data, stall, serial_done,
    input  dqueue_en, invalid_en, issue_valid, issue_data, pair_cnt, stall_cnt
  );
endinterface

// File: rtl/dispatch_pair.sv
// Dual-issue dispatch stage. Looks at the two FIFO head entries, decides to
// issue 2/1/0 instructions, registers the issue bundle and tells the FIFO how
// many heads to retire. A serializing op parks the stage in SERIAL until the
// back end reports serial_done.
// Build option: define DISPATCH_PAIR_DUAL_ISSUE_EN to allow pairing; without it
// the stage is single-issue with the same ports.
module dispatch_pair #(
  parameter int ENTRY_W = 64,
  parameter int CNT_W   = 32
) (
  input logic           clk,
  input logic           rst,
  dispatch_pair_if.slave bus
);

  typedef enum logic {RUN = 1'b0, SERIAL = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [ENTRY_W-1:0]      w_slot0;
  logic [ENTRY_W-1:0]      w_slot1;
  logic                    w_canIssue;
  logic                    w_pairOk;
  logic                    w_issue0;
  logic                    w_issue1;
  logic [1:0]              r_issueValid;
  logic [1:0][ENTRY_W-1:0] r_issueData;
  logic [CNT_W-1:0]        r_pairCnt;
  logic [CNT_W-1:0]        r_stallCnt;

  assign w_slot0 = bus.head_data[0];
  assign w_slot1 = bus.head_data[1];

`ifdef DISPATCH_PAIR_DUAL_ISSUE_EN
  logic w_raw;
  logic w_memClash;
  logic w_mdClash;
  logic w_serialAny;

  // rd==0 is the hardwired zero register, so writing it never creates a RAW.
  assign w_raw       = w_slot0[15] && (w_slot0[4:0] != 5'd0) &&
                       ((w_slot0[4:0] == w_slot1[9:5]) || (w_slot0[4:0] == w_slot1[14:10]));
  assign w_memClash  = w_slot0[16] && w_slot1[16];
  assign w_mdClash   = w_slot0[17] && w_slot1[17];
  assign w_serialAny = w_slot0[18] || w_slot1[18];
  assign w_pairOk    = bus.head_valid[1] && !w_raw && !w_memClash && !w_mdClash &&
                       !w_serialAny && !w_slot0[19];
`else
  assign w_pairOk = 1'b0;
`endif

  // Slot0 issues whenever the stage is free to act; slot1 only rides along with it.
  assign w_canIssue = !rst && (r_state == RUN) && !bus.stall && !bus.flush && bus.head_valid[0];
  assign w_issue0   = w_canIssue;
  assign w_issue1   = w_canIssue && w_pairOk;

  assign bus.invalid_en  = {w_issue1, w_issue0};
  assign bus.dqueue_en   = 2'b11;
  assign bus.issue_valid = r_issueValid;
  assign bus.issue_data  = r_issueData;
  assign bus.pair_cnt    = r_pairCnt;
  assign bus.stall_cnt   = r_stallCnt;

  // Serialization FSM next state; flush always drops back to RUN.
  always_comb begin
    w_stateNext = r_state;
    if (bus.flush) begin
      w_stateNext = RUN;
    end else begin
      case (r_state)
        RUN:     if (w_issue0 && w_slot0[18]) w_stateNext = SERIAL;
        SERIAL:  if (bus.serial_done) w_stateNext = RUN;
        default: w_stateNext = RUN;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_stateNext;
  end

  // Issue bundle: flush clears valid, stall holds everything, otherwise load or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issueValid <= 2'b00;
      r_issueData  <= '0;
    end else if (bus.flush) begin
      r_issueValid <= 2'b00;
    end else if (!bus.stall) begin
      if (w_issue0) begin
        r_issueValid   <= {w_issue1, 1'b1};
        r_issueData[0] <= w_slot0;
        r_issueData[1] <= bus.head_valid[1] ? w_slot1 : '0;
      end else begin
        r_issueValid <= 2'b00;
      end
    end
  end

  // Performance counters; only reset clears them, both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pairCnt  <= '0;
      r_stallCnt <= '0;
    end else begin
      if (w_issue1)
        r_pairCnt <= r_pairCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (bus.head_valid[0] && !w_issue0 && !bus.flush)
        r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
